// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM responder: word-addressable memory behind one decoder slot,
// with programmable wait states, byte/halfword/word writes and ERROR responses.
module ahbl_sram_slave #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [23:0] addr_reg;
  logic [2:0]  size_reg;
  logic        write_reg;
  logic [31:0] mem [0:(2**AW)-1];

  logic          acc, beyond, misalign, illegal;
  logic [3:0]    lane_en;
  logic [AW-1:0] word;

  assign acc      = HSEL & HREADY & HTRANS[1];
  assign misalign = ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0]));
  assign illegal  = (HSIZE > 3'd2) | misalign | beyond;
  assign word     = addr_reg[AW+1:2];

  // Out-of-page bits only exist when the memory is smaller than the 16 MB page.
  if (AW + 2 < 24) begin : g_range
    logic unused_bits;
    assign beyond      = |HADDR[23:AW+2];
    assign unused_bits = ^{HADDR[31:24], addr_reg[23:AW+2]};
  end else begin : g_full
    logic unused_bits;
    assign beyond      = 1'b0;
    assign unused_bits = ^HADDR[31:24];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (size_reg == 3'd2)
                       | ((size_reg == 3'd1) & (addr_reg[1] == LANE[1]))
                       | ((size_reg == 3'd0) & (addr_reg[1:0] == LANE));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 24'd0;
      size_reg  <= 3'd0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (acc) begin
        addr_reg  <= HADDR[23:0];
        size_reg  <= HSIZE;
        write_reg <= HWRITE;
      end
    end
  end

  // Commit happens on the edge that ends DATA; reset on that edge drops it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state_reg == S_DATA && write_reg) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = 32'd0;
    case (state_reg)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_next  = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      default: begin
        if (state_reg == S_DATA) HRDATA = mem[word];
        if (state_reg == S_ERR2) HRESP = 1'b1;
        if (state_reg != S_IDLE) state_next = S_IDLE;
        if (acc) begin
          if (illegal) begin
            state_next = S_ERR1;
          end else if (WS == 4'd0) begin
            state_next = S_DATA;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WS;
          end
        end
      end
    endcase
  end

endmodule

// File: doc/ahbl_sram_slave.md
# ahbl_sram_slave

AHB-Lite responder that backs one address page of the bus with an on-chip word-addressable memory. It supports configurable wait states and byte/halfword/word writes, and returns a two-cycle ERROR response for illegal accesses. It sits behind the system bus decoder on one `HSEL_Sx`/`HREADY_Sx`/`HRDATA_Sx` slot; the decoder decodes `HADDR[31:24]`, and this block decodes `HADDR[23:0]`.

## Interface
- `AW`, 10: word-address width; memory depth is 2^AW 32-bit words. Legal range 2..22.
- `WAIT_STATES`, 1: number of `HREADYOUT`-low cycles inserted in every OKAY data phase. Legal range 0..15.
- `HCLK`  in  1  bus clock; all logic on the rising edge.
- `HRESET`  in  1  reset, synchronous, active-high.
- `HSEL`  in  1  slave select from the bus decoder.
- `HADDR`  in  32  address; bits [23:0] are used.
- `HTRANS`  in  2  transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
- `HSIZE`  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
- `HWRITE`  in  1  1 = write, 0 = read.
- `HREADY`  in  1  bus-level ready; an address phase is sampled only when this is 1.
- `HWDATA`  in  32  write data, valid in the data phase.
- `HREADYOUT`  out  1  this slave's ready; the decoder returns it as `HREADY_Sx`.
- `HRDATA`  out  32  read data.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept condition: `acc = HSEL & HREADY & HTRANS[1]`. On `acc`, latch `HADDR[23:0]`, `HSIZE` and `HWRITE` into address-phase registers.
- IDLE and BUSY transfers, and cycles with `HSEL` low, produce no transfer. The slave returns zero-wait OKAY for them.
- Illegal access, flagged at accept time (any one is sufficient):
  - `HSIZE > 2`;
  - `HSIZE == 1` and `HADDR[0] == 1`;
  - `HSIZE == 2` and `HADDR[1:0] != 0`;
  - `HADDR[23:AW+2] != 0` (beyond memory depth).
- Byte lanes (little-endian):
  - byte: lane `HADDR[1:0]`;
  - halfword: lanes {1,0} or {3,2}, selected by `HADDR[1]`;
  - word: all four lanes.
- Write commit: the selected lanes of `HWDATA` are written at the rising edge ending the DATA state. Unselected lanes are unchanged. Illegal writes never modify memory.
- Read: in DATA, `HRDATA` = full 32-bit word at the latched address, read combinationally from the array. All lanes are driven regardless of `HSIZE`. In all other states `HRDATA = 0`.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2. The wait counter `cnt` is 4 bits.
  - Dispatch on `acc`: illegal → ERR1; else if `WAIT_STATES == 0` → DATA; else → WAIT with `cnt = WAIT_STATES`.
  - IDLE: `HREADYOUT=1`, `HRESP=0`. Dispatch on `acc`, else stay in IDLE.
  - WAIT: `HREADYOUT=0`, `HRESP=0`. `cnt` decrements each cycle; when `cnt == 1`, go to DATA.
  - DATA: `HREADYOUT=1`, `HRESP=0`. The transfer completes here. Dispatch on `acc` (pipelined next address phase), else go to IDLE.
  - ERR1: `HREADYOUT=0`, `HRESP=1`. Always go to ERR2.
  - ERR2: `HREADYOUT=1`, `HRESP=1`. Dispatch on `acc`, else go to IDLE.
- No `acc` is possible in WAIT or ERR1, because `HREADY` is 0 while this slave is the active data-phase slave.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: state IDLE, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `cnt=0`, address-phase registers 0.
- Reset asserted mid-transfer (WAIT/DATA/ERR*): the FSM returns to IDLE on the next edge. A pending write is dropped; no partial lane write occurs.
- OKAY transfer latency: address phase, then `WAIT_STATES` low-ready cycles, then one DATA cycle. Total `WAIT_STATES+1` cycles after the address phase.
- ERROR response: exactly 2 cycles (ERR1, then ERR2), independent of `WAIT_STATES`.
- Back-to-back: an address phase overlapping DATA or ERR2 is accepted with no bubble.
- Write followed by read of the same address, pipelined: the read's DATA cycle falls at or after the write's commit edge, so it returns the new value. No forwarding logic is needed.
- Maximum address: word index 2^AW − 1 is legal; index 2^AW is ERROR.

## Test plan
- Reset then idle: hold `HRESET=1` for 2 cycles, then drive `HTRANS=0` → `HREADYOUT=1`, `HRESP=0`, `HRDATA=0` every cycle.
- Word write/read, `WAIT_STATES=1`: write `0xCAFEBABE` to `0x000010`, then read it back → each data phase has exactly 1 low-ready cycle; read returns `0xCAFEBABE`.
- Byte/halfword lanes: word-write `0x11223344` to `0x20`; then byte-write `0xAA` at `0x21`; then halfword-write `0xBBBB` at `0x22`; then word-read `0x20` → `0xBBBBAA44`.
- Errors: halfword at `0x01`, word at `0x06`, `HSIZE=3`, and address `4<<AW` → each gives ERR1 (`HREADYOUT=0`, `HRESP=1`) then ERR2 (`HREADYOUT=1`, `HRESP=1`); a follow-up read shows memory unchanged.
- Pipelined, `WAIT_STATES=0`: write `0x5A5A5A5A` to `0x40` with a read of `0x40` in the next cycle → read returns `0x5A5A5A5A`; no low-ready cycles.
- Reset mid-WAIT, `WAIT_STATES=3`: start a write of `0xFFFFFFFF` to `0x80` over prior contents `0`, assert `HRESET` in the 2nd wait cycle → the next cycle is IDLE with `HREADYOUT=1`; a read of `0x80` returns `0`.
